squid_error_corrector: RTL
==========================

// Module: squid_error_corrector
// PURPOSE
// - Consumes one codeword per handshake: 8 data symbols, 4 parity symbols and the four GF(16) syndromes
//   computed for them, and corrects at most one erroneous 4-bit symbol.
// - Sits directly downstream of the SQUID syndrome-generation stage and upstream of the decoder output register.
// - Iterative locator: tests one symbol position per clock against the parity-check columns, then emits
//   the corrected data symbols, a status code and the error position.
// PARAMETERS
// - NUM_DATA  8  data symbols per codeword; only the default is legal.
// - NUM_PAR   4  parity symbols and syndromes; only the default is legal.
// - SYM_W     4  symbol width in bits, GF(2^4) with x^4+x+1; only the default is legal.
// PORTS
// - clk        in   1             clock; all state updates on the rising edge.
// - rst        in   1             asynchronous, active-high reset.
// - in_valid   in   1             vp/pp/syn are valid.
// - in_ready   out  1             block can accept a codeword.
// - vp         in   [3:0][7:0]    received data symbols.
// - pp         in   [3:0][3:0]    received parity symbols.
// - syn        in   [3:0][3:0]    syndromes syn[0]..syn[3].
// - out_valid  out  1             result is valid.
// - out_ready  in   1             consumer accepts the result.
// - dout       out  [3:0][7:0]    corrected data symbols.
// - status     out  2             00 = NE (no error), 01 = CE (corrected), 10 = DUE (uncorrectable), 11 never driven.
// - err_pos    out  4             position of the corrected symbol: 0-7 = vp[0..7], 8-11 = pp[0..3]; 0 unless status is CE.
// BEHAVIOUR
// - Reset: FSM goes to IDLE; in_ready=1, out_valid=0, dout=0, status=00, err_pos=0; all capture registers cleared.
// - FSM states:
//   - IDLE: in_ready=1. On in_valid&&in_ready, capture vp, pp and syn. If all syndromes are zero, go to DONE;
//     otherwise set idx=0 and go to SEARCH.
//   - SEARCH: in_ready=0. Each cycle tests position idx:
//     - e = syn[0]*HINV0[idx], the GF product of syn[0] with the inverse of column entry H[0][idx].
//     - Hit when syn[k] == e*H[k][idx] for k=1,2,3.
//     - On a hit: record e and idx, status=CE. A data position XORs e into dout[idx]; a parity position
//       leaves dout equal to vp.
//     - After idx=11 with no hit: status=DUE, dout=vp, err_pos=0.
//     - idx increments by 1 per cycle and never wraps past 11.
//   - DONE: out_valid=1. Outputs are held stable until out_ready. On out_valid&&out_ready, go to IDLE;
//     in_ready rises the following cycle, with no same-cycle bypass.
// - A zero syndrome gives status=NE and dout=vp.
// - A hit with e==0 cannot occur, because syn[0]!=0 is required for a hit. A nonzero syndrome with syn[0]==0 therefore ends as DUE.
// - Latency is counted from the accept edge (cycle 0); listed in CONFIGURATION.
// - A second in_valid while busy is ignored because in_ready=0. Input data need not stay stable after accept.
// - Reset asserted mid-SEARCH or in DONE aborts the operation: out_valid drops asynchronously and no partial result is emitted.
// - All GF arithmetic is 4-bit; addition is XOR.
// CONFIGURATION
// - Macro SQUID_EARLY_TERM_EN.
// - Defined: SEARCH exits on the first hit.
//   - Zero syndrome: out_valid at cycle 1.
//   - Hit at position j: out_valid at cycle j+2.
//   - DUE: out_valid at cycle 13.
// - Undefined: SEARCH always scans all 12 positions and latches only the first hit. A zero syndrome also
//   passes through the scan. out_valid is always at cycle 13, giving constant data-independent latency.
// STRUCTURE
// - Package squid_pkg holds:
//   - SYM_W, NUM_DATA, NUM_PAR and status_e {NE, CE, DUE}.
//   - H[4][12] columns as syn0,syn1,syn2,syn3:
//     - vp0: 9,13,15,14 | vp1: 13,14,10,11 | vp2: 15,10,12,8 | vp3: 14,11,8,9
//     - vp4: 7,6,1,7 | vp5: 10,8,15,12 | vp6: 5,2,10,4 | vp7: 11,9,12,13
//     - pp0: 12,15,8,10 | pp1: 6,7,1,6 | pp2: 3,5,15,2 | pp3: 8,12,10,15
//   - HINV0[12], the GF inverses of row H[0]; for example HINV0[0]=2.
//   - state_e {IDLE, SEARCH, DONE}.
// - Sub-module: a single combinational position checker, sym_pos_check, built from 4 existing GFMULT
//   instances fed by muxed package constants and instantiated once. The FSM, idx counter and capture
//   registers live in the top module.
// TESTING
// - vp=0, pp=0, syn={0,0,0,0} -> status=NE, dout=0, err_pos=0; out_valid at cycle 1 with EARLY_TERM, cycle 13 without.
// - vp=0, syn={9,13,15,14} (e=1 at vp0) -> status=CE, err_pos=0, dout[0]=1, all other symbols 0; out_valid at cycle 2 with EARLY_TERM.
// - vp=0, syn={8,12,10,15} (e=1 at pp3) -> status=CE, err_pos=11, dout=0; out_valid at cycle 13 in both builds.
// - syn={4,3,5,5} (errors at vp0 and vp1) -> status=DUE, err_pos=0, dout=vp; out_valid at cycle 13.
// - Any CE case with out_ready held low for 5 cycles -> out_valid, dout, status and err_pos stay stable;
//   in_ready=0 throughout; in_ready=1 the cycle after the handshake.
// - rst pulsed at cycle 4 of a search, then a NE codeword applied -> no stale result appears;
//   the NE result emerges with the normal latency.

Source files
------------

// File: rtl/squid_pkg.sv
// squid_pkg: shared constants for the SQUID single-symbol error corrector.
// - Code geometry (SYM_W, NUM_DATA, NUM_PAR, NUM_POS).
// - status_e result codes and state_e corrector FSM states.
// - H: parity-check matrix, row k = contribution of each position to syn[k].
//   Columns 0-7 are vp0..vp7 and columns 8-11 are pp0..pp3.
// - HINV0: GF(16) inverses of row H[0]. They turn syn[0] into the error value e.
package squid_pkg;

  localparam int SYM_W    = 4;
  localparam int NUM_DATA = 8;
  localparam int NUM_PAR  = 4;
  localparam int NUM_POS  = NUM_DATA + NUM_PAR;

  typedef enum logic [1:0] {
    NE  = 2'b00,
    CE  = 2'b01,
    DUE = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    DONE   = 2'b10
  } state_e;

  localparam logic [3:0] H [4][12] = '{
    '{4'd9,  4'd13, 4'd15, 4'd14, 4'd7, 4'd10, 4'd5,  4'd11, 4'd12, 4'd6, 4'd3,  4'd8 },
    '{4'd13, 4'd14, 4'd10, 4'd11, 4'd6, 4'd8,  4'd2,  4'd9,  4'd15, 4'd7, 4'd5,  4'd12},
    '{4'd15, 4'd10, 4'd12, 4'd8,  4'd1, 4'd15, 4'd10, 4'd12, 4'd8,  4'd1, 4'd15, 4'd10},
    '{4'd14, 4'd11, 4'd8,  4'd9,  4'd7, 4'd12, 4'd4,  4'd13, 4'd10, 4'd6, 4'd2,  4'd15}
  };

  localparam logic [3:0] HINV0 [12] = '{
    4'd2, 4'd4, 4'd8, 4'd3, 4'd6, 4'd12, 4'd11, 4'd5, 4'd10, 4'd7, 4'd14, 4'd15
  };

endpackage

// File: rtl/GFMULT.sv
// GFMULT: combinational GF(2^4) multiplier, field polynomial x^4+x+1.
// Ports: a, b - operands; p - product a*b.
module GFMULT (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);

  // Shift-and-add: t walks through a*x^i, reduced modulo x^4+x+1 each step.
  always_comb begin
    logic [3:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ {2'b00, t[3], t[3]};
    end
  end

endmodule

// File: rtl/sym_pos_check.sv
// sym_pos_check: tests whether the syndromes are explained by a single
// error at one codeword position.
// Ports: idx - position under test (0-7 data, 8-11 parity);
//        syn - syndromes syn[0]..syn[3];
//        hit - syndromes match e * column idx;
//        e   - error value syn[0] * HINV0[idx].
module sym_pos_check (
  input  logic [3:0]      idx,
  input  logic [3:0][3:0] syn,
  output logic            hit,
  output logic [3:0]      e
);
  import squid_pkg::*;

  logic [3:0] c_inv, c1, c2, c3;
  logic [3:0] p1, p2, p3;

  // Positions past the last column read zero constants. The counter never
  // reaches them, but the mux stays fully defined.
  always_comb begin
    c_inv = '0;
    c1    = '0;
    c2    = '0;
    c3    = '0;
    if (idx < 4'(NUM_POS)) begin
      c_inv = HINV0[idx];
      c1    = H[1][idx];
      c2    = H[2][idx];
      c3    = H[3][idx];
    end
  end

  GFMULT u_mul_e  (.a(syn[0]), .b(c_inv), .p(e));
  GFMULT u_mul_s1 (.a(e),      .b(c1),    .p(p1));
  GFMULT u_mul_s2 (.a(e),      .b(c2),    .p(p2));
  GFMULT u_mul_s3 (.a(e),      .b(c3),    .p(p3));

  // A zero syn[0] gives e=0. That only "matches" an all-zero syndrome,
  // which is not an error, so it is excluded here.
  assign hit = (syn[0] != '0) && (p1 == syn[1]) && (p2 == syn[2]) && (p3 == syn[3]);

endmodule

// File: rtl/squid_error_corrector.sv
// squid_error_corrector: single-symbol GF(16) corrector for SQUID codewords.
// One codeword (8 data symbols, 4 parity symbols, 4 syndromes) is accepted
// per handshake. One position is tested per clock, and then the corrected
// data, a status code and the error position are presented.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   in_valid/in_ready, vp, pp, syn - codeword input handshake
//   out_valid/out_ready            - result handshake
//   dout    - corrected data symbols (symbol i = bits 4i+3:4i)
//   status  - 00 NE, 01 CE, 10 DUE
//   err_pos - corrected position (0-7 data, 8-11 parity), 0 unless CE
// Build option SQUID_EARLY_TERM_EN: when defined, the search stops at the
// first hit and a zero syndrome skips the search. When undefined, all 12
// positions are scanned, so the latency is constant.
module squid_error_corrector (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0][7:0] vp,
  input  logic [3:0][3:0] pp,
  input  logic [3:0][3:0] syn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0][7:0] dout,
  output logic [1:0]      status,
  output logic [3:0]      err_pos
);
  import squid_pkg::*;

  localparam logic [3:0] LAST_POS = 4'(NUM_POS - 1);

  state_e state, state_nx;

  logic [NUM_DATA-1:0][SYM_W-1:0] vp_sym, cap_vp, dout_r, res_dout;
  logic [NUM_PAR-1:0][SYM_W-1:0]  cap_pp, cap_syn;
  logic [3:0] idx, err_e, err_idx, err_pos_r, res_pos;
  logic [3:0] e_cur, e_sel, pos_sel;
  logic       found, found_now, hit, last, cap_zero, load_res, load_zero;
  status_e    status_r, res_status;
  logic       unused_pp;

  // The port is declared as a flat 32-bit bundle. Here it is viewed as
  // eight 4-bit symbols.
  assign vp_sym = vp;

  // Parity symbols are captured with the codeword. Only data symbols are
  // emitted, so a parity-position error only affects status and err_pos.
  assign unused_pp = ^cap_pp;

  sym_pos_check u_chk (
    .idx (idx),
    .syn (cap_syn),
    .hit (hit),
    .e   (e_cur)
  );

  assign last      = (idx == LAST_POS);
  assign cap_zero  = (cap_syn == '0);
  assign found_now = found || hit;
  // Only the first hit counts. A hit recorded earlier in the scan takes
  // precedence over the position under test now.
  assign e_sel     = found ? err_e   : e_cur;
  assign pos_sel   = found ? err_idx : idx;

  always_comb begin
    res_dout   = cap_vp;
    res_status = DUE;
    res_pos    = '0;
    if (cap_zero) begin
      res_status = NE;
    end else if (found_now) begin
      res_status = CE;
      res_pos    = pos_sel;
      if (pos_sel < 4'(NUM_DATA))
        res_dout[pos_sel[2:0]] = cap_vp[pos_sel[2:0]] ^ e_sel;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_res  = 1'b0;
    load_zero = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef SQUID_EARLY_TERM_EN
          if (syn == '0) begin
            state_nx  = DONE;
            load_zero = 1'b1;
          end else begin
            state_nx = SEARCH;
          end
`else
          state_nx = SEARCH;
`endif
        end
      end
      SEARCH: begin
`ifdef SQUID_EARLY_TERM_EN
        if (hit || last) begin
`else
        if (last) begin
`endif
          state_nx = DONE;
          load_res = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cap_vp    <= '0;
      cap_pp    <= '0;
      cap_syn   <= '0;
      found     <= 1'b0;
      err_e     <= '0;
      err_idx   <= '0;
      dout_r    <= '0;
      status_r  <= NE;
      err_pos_r <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        cap_vp  <= vp_sym;
        cap_pp  <= pp;
        cap_syn <= syn;
        idx     <= '0;
        found   <= 1'b0;
      end else if (state == SEARCH) begin
        if (!last) idx <= idx + 4'd1;
        if (hit && !found) begin
          found   <= 1'b1;
          err_e   <= e_cur;
          err_idx <= idx;
        end
      end
      // Result registers load only when DONE is entered. This keeps them
      // stable while the result is back-pressured.
      if (load_zero) begin
        dout_r    <= vp_sym;
        status_r  <= NE;
        err_pos_r <= '0;
      end else if (load_res) begin
        dout_r    <= res_dout;
        status_r  <= res_status;
        err_pos_r <= res_pos;
      end
    end
  end

  assign dout    = dout_r;
  assign status  = status_r;
  assign err_pos = err_pos_r;

endmodule
